modular_carry_reducer: RTL and testbench

//  Sequential successor to the combinational redundant-form propagator.
//  - Accepts NUM_ELEMENTS redundant limbs A[i] (BIT_LEN bits, weight 2^(WORD_LEN*i)).
//  - Carry-propagates them limb-serially.
//  - Folds every bit above DATA_LEN back in using FOLD_CONST = 2^DATA_LEN mod MODULUS.
//  - Returns a fully reduced result in [0, MODULUS), with no fixed 2-bit overflow limit.
//  - Sits between the redundant-form multiplier/ladder datapath and any consumer needing canonical field elements.

---
 rtl/modular_carry_reducer.sv | 144 ++++++++++++++
 tb/tb_modular_carry_reducer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/modular_carry_reducer.sv
// Limb-serial carry propagation and modular fold of a redundant-form operand.
// Produces the canonical value S mod MODULUS with a valid/ready handshake on both sides.
module modular_carry_reducer #(
  parameter int                  NUM_ELEMENTS = 17,
  parameter int                  BIT_LEN      = 17,
  parameter int                  WORD_LEN     = 16,
  parameter int                  DATA_LEN     = 256,
  parameter logic [DATA_LEN-1:0] MODULUS      = 256'hfffffffeffffffffffffffffffffffffffffffff00000000ffffffffffffffff,
  parameter logic [DATA_LEN-1:0] FOLD_CONST   = 256'h0000000100000000000000000000000000000000ffffffff0000000000000001,
  parameter int                  MAX_FOLDS    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_LEN-1:0]  A [NUM_ELEMENTS],
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] result,
  output logic                fold_err
);

  localparam int HI_LEN  = WORD_LEN*(NUM_ELEMENTS-1) + BIT_LEN + $clog2(NUM_ELEMENTS) - DATA_LEN;
  localparam int ACC_LEN = DATA_LEN + HI_LEN;
  localparam int IDX_W   = $clog2(NUM_ELEMENTS);
  localparam int SH_W    = $clog2(ACC_LEN);
  localparam int FOLD_W  = $clog2(MAX_FOLDS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACCUM = 3'd1;
  localparam logic [2:0] S_FOLD  = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [ACC_LEN-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FOLD_W-1:0]   folds_q, folds_d;
  logic                err_q, err_d;
  logic [DATA_LEN-1:0] result_q, result_d;
  logic                out_valid_q, out_valid_d;
  logic                fold_err_q, fold_err_d;
  logic [BIT_LEN-1:0]  limb_q [NUM_ELEMENTS];

  logic [SH_W-1:0]     shamt;
  logic [ACC_LEN-1:0]  addend;
  logic [HI_LEN-1:0]   hi_part;
  logic [DATA_LEN-1:0] lo_part;
  logic [ACC_LEN-1:0]  fold_sum;

  assign shamt    = SH_W'(idx_q) * SH_W'(WORD_LEN);
  assign addend   = ACC_LEN'(limb_q[idx_q]) << shamt;
  assign hi_part  = acc_q[ACC_LEN-1:DATA_LEN];
  assign lo_part  = acc_q[DATA_LEN-1:0];
  // High part times 2^DATA_LEN mod p, kept at full ACC_LEN width so nothing is lost.
  assign fold_sum = ACC_LEN'(lo_part) + ACC_LEN'(hi_part) * ACC_LEN'(FOLD_CONST);

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign fold_err  = fold_err_q;

  // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    folds_d     = folds_q;
    err_d       = err_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    fold_err_d  = fold_err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          idx_d   = '0;
          folds_d = '0;
          err_d   = 1'b0;
        end
      end
      S_ACCUM: begin
        acc_d = acc_q + addend;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_ELEMENTS - 1)) state_d = S_FOLD;
      end
      S_FOLD: begin
        if (hi_part == '0) begin
          state_d = S_FINAL;
        end else if (folds_q == FOLD_W'(MAX_FOLDS)) begin
          err_d   = 1'b1;
          state_d = S_FINAL;
        end else begin
          acc_d   = fold_sum;
          folds_d = folds_q + 1'b1;
        end
      end
      S_FINAL: begin
        // A single conditional subtract suffices because 2^DATA_LEN < 2*MODULUS.
        result_d    = (lo_part >= MODULUS) ? lo_part - MODULUS : lo_part;
        fold_err_d  = err_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      folds_q     <= '0;
      err_q       <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      fold_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      folds_q     <= folds_d;
      err_q       <= err_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      fold_err_q  <= fold_err_d;
    end
  end

  // NOTE: the limb store is pure data qualified by the FSM, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && in_valid) limb_q <= A;
  end

endmodule

// File: tb/tb_modular_carry_reducer.sv
// Self-checking bench for modular_carry_reducer against a bigint S mod p reference.
module tb_modular_carry_reducer;

  localparam int NE = 17;
  localparam int BL = 17;
  localparam int WL = 16;
  localparam int DL = 256;
  localparam logic [DL-1:0] P  = 256'hfffffffeffffffffffffffffffffffffffffffff00000000ffffffffffffffff;
  localparam logic [DL-1:0] FC = 256'h0000000100000000000000000000000000000000ffffffff0000000000000001;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [BL-1:0] a_tb [NE];
  logic          out_valid;
  logic          out_ready;
  logic [DL-1:0] result;
  logic          fold_err;

  int n_cmp = 0;
  int n_bad = 0;

  modular_carry_reducer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_tb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .fold_err  (fold_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DL-1:0] got, input logic [DL-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact integer sum of weighted limbs, reduced with the % operator.
  function automatic logic [DL-1:0] model_mod();
    logic [DL+63:0] s;
    s = '0;
    for (int i = 0; i < NE; i++) s += (DL+64)'(a_tb[i]) << (WL*i);
    return DL'(s % (DL+64)'(P));
  endfunction

  task automatic clear_limbs();
    for (int i = 0; i < NE; i++) a_tb[i] = '0;
  endtask

  // One full transaction: accept, wait for result, optional back-pressure, handshake.
  task automatic run_op(input string tag, input logic [DL-1:0] exp, input int lat_lo,
                        input int lat_hi, input bit noisy, input int hold);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = noisy;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (noisy) for (int i = 0; i < NE; i++) a_tb[i] = BL'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) check({tag, "_timeout"}, out_valid, 1);
    check({tag, "_result"}, result, exp);
    check({tag, "_fold_err"}, fold_err, 0);
    if (lat < lat_lo || lat > lat_hi) check({tag, "_latency"}, lat, lat_hi);
    else n_cmp++;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "_hold_result"}, result, exp);
      check({tag, "_hold_in_ready"}, in_ready, 0);
      check({tag, "_hold_valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    logic [DL-1:0] mod_v;
    logic [DL-1:0] exp;
    bit            seen;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    clear_limbs();
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_fold_err", fold_err, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Zero operand: no folds, 19 cycles.
    clear_limbs();
    run_op("zero", 0, 19, 19, 1'b0, 0);

    clear_limbs(); a_tb[0] = 1;
    run_op("one", 1, 19, 21, 1'b0, 0);

    // 2^256 folds exactly once.
    clear_limbs(); a_tb[NE-1] = 1;
    run_op("two256", FC, 20, 20, 1'b0, 0);

    mod_v = P;
    clear_limbs();
    for (int i = 0; i < NE-1; i++) a_tb[i] = BL'(mod_v[WL*i +: WL]);
    run_op("eq_p", 0, 19, 21, 1'b0, 0);
    a_tb[0] = a_tb[0] + 5;
    run_op("p_plus5", 5, 19, 21, 1'b0, 0);

    for (int i = 0; i < NE; i++) a_tb[i] = 17'h1FFFF;
    run_op("all_ones", model_mod(), 19, 21, 1'b0, 0);

    // Back-pressure: hold result for 5 cycles with busy-time noise on the inputs.
    for (int i = 0; i < NE; i++) a_tb[i] = BL'($urandom);
    run_op("hold", model_mod(), 19, 21, 1'b1, 5);

    for (int t = 0; t < 1000; t++) begin
      for (int i = 0; i < NE; i++) a_tb[i] = BL'($urandom);
      exp = model_mod();
      run_op("rand", exp, 19, 21, t[2], 0);
    end

    // Reset in cycle 8 of ACCUM abandons the operand.
    for (int i = 0; i < NE; i++) a_tb[i] = BL'($urandom);
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_in_ready_low", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("midrst_no_valid", seen, 0);
    check("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < NE; i++) a_tb[i] = BL'($urandom);
    run_op("after_rst", model_mod(), 19, 21, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
